// File: rtl/edge_detect_multi.sv
// Multi-channel input conditioner: per channel an N-stage synchroniser, a debounce
// filter, mode-gated edge pulse, filtered level and a sticky, clearable event flag.
module edge_detect_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     signal,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     clear,
  output logic [CHANNELS-1:0]     pulse,
  output logic [CHANNELS-1:0]     level,
  // "event" is a reserved word, hence the sticky flag is event_flag
  output logic [CHANNELS-1:0]     event_flag
);

  localparam int unsigned     CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic [CHANNELS-1:0]                  event_q, event_d;
  logic [CHANNELS-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], signal};
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (s[c] == level_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_LAST) begin
        // new level held long enough: accept it and report the edge if enabled
        level_d[c] = s[c];
        cnt_d[c]   = '0;
        pulse_d[c] = s[c] ? mode[2*c] : mode[2*c+1];
      end else begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
    event_d = pulse_d | (event_q & ~clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      event_q <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      event_q <= event_d;
    end
  end

  assign pulse      = pulse_q;
  assign level      = level_q;
  assign event_flag = event_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: fixed vectors, hand-written corner sequences and
// random stimulus against a history-window reference model, on two configurations.
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sig_a, clr_a, pulse_a, level_a, event_a;
  logic [7:0] mode_a;
  logic [3:0] sig_b, clr_b, pulse_b, level_b, event_b;
  logic [7:0] mode_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state: packed input history (4 bits per edge, newest in [3:0])
  logic [63:0] hist_a, hist_b;
  logic [3:0]  lvl_a, pul_a, evt_a, lvl_b, pul_b, evt_b;

  typedef struct packed {
    logic [3:0] sig;
    logic [3:0] clr;
    logic [3:0] pul;
    logic [3:0] lvl;
    logic [3:0] evt;
  } vec_t;
  vec_t tbl [27];

  always #5 clk = ~clk;

  edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .signal(sig_a), .mode(mode_a), .clear(clr_a),
    .pulse(pulse_a), .level(level_a), .event_flag(event_a)
  );

  edge_detect_multi #(.CHANNELS(4), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .signal(sig_b), .mode(mode_b), .clear(clr_b),
    .pulse(pulse_b), .level(level_b), .event_flag(event_b)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A channel accepts a new level when the synchronised samples seen at the last
  // nf edges all differ from its current level; s at this edge is the input ns edges ago.
  task automatic model_step(input int unsigned ns, input int unsigned nf,
                            input logic [3:0] sig, input logic [7:0] md, input logic [3:0] clr,
                            inout logic [63:0] hist, inout logic [3:0] lvl,
                            output logic [3:0] pul, inout logic [3:0] evt);
    logic [3:0] smp;
    bit         held;
    hist = {hist[59:0], sig};
    pul  = '0;
    for (int c = 0; c < 4; c++) begin
      held = 1'b1;
      for (int unsigned i = 0; i < nf; i++) begin
        smp = hist[4*(ns+i) +: 4];
        if (smp[c] == lvl[c]) held = 1'b0;
      end
      if (held) begin
        lvl[c] = ~lvl[c];
        pul[c] = lvl[c] ? md[2*c] : md[2*c+1];
      end
    end
    evt = pul | (evt & ~clr);
  endtask

  task automatic model_reset();
    hist_a = '0; lvl_a = '0; pul_a = '0; evt_a = '0;
    hist_b = '0; lvl_b = '0; pul_b = '0; evt_b = '0;
  endtask

  task automatic step();
    logic [3:0] pa, pb;
    @(posedge clk);
    model_step(2, 4, sig_a, mode_a, clr_a, hist_a, lvl_a, pa, evt_a);
    pul_a = pa;
    model_step(3, 1, sig_b, mode_b, clr_b, hist_b, lvl_b, pb, evt_b);
    pul_b = pb;
    #1;
    check("model_a", 16'({pulse_a, level_a, event_a}), 16'({pul_a, lvl_a, evt_a}));
    check("model_b", 16'({pulse_b, level_b, event_b}), 16'({pul_b, lvl_b, evt_b}));
  endtask

  // called #1 after an edge: assert reset mid-cycle, check outputs, release before next edge
  task automatic async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_a", 16'({pulse_a, level_a, event_a}), 16'h0);
    check("rst_b", 16'({pulse_b, level_b, event_b}), 16'h0);
    #2 reset_n = 1'b1;
  endtask

  task automatic set_rows(input int lo, input int hi, input logic [3:0] sig, input logic [3:0] clr,
                          input logic [3:0] pul, input logic [3:0] lvl, input logic [3:0] evt);
    for (int i = lo; i <= hi; i++) tbl[i] = '{sig, clr, pul, lvl, evt};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wv [160];
    int unsigned k, cnt;
    logic [1:0]  mds [4];
    int unsigned exp_cnt [4];

    // ch0 rise (mode 01); ch1 (mode 11) 3-cycle glitch, then a 4-cycle pulse
    set_rows(0,  4,  4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    set_rows(5,  5,  4'h1, 4'h0, 4'h1, 4'h1, 4'h1);
    set_rows(6,  6,  4'h1, 4'h0, 4'h0, 4'h1, 4'h1);
    set_rows(7,  7,  4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
    set_rows(8,  10, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0);
    set_rows(11, 15, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
    set_rows(16, 19, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0);
    set_rows(20, 20, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
    set_rows(21, 21, 4'h1, 4'h0, 4'h2, 4'h3, 4'h2);
    set_rows(22, 24, 4'h1, 4'h0, 4'h0, 4'h3, 4'h2);
    set_rows(25, 25, 4'h1, 4'h0, 4'h2, 4'h1, 4'h2);
    set_rows(26, 26, 4'h1, 4'h0, 4'h0, 4'h1, 4'h2);

    reset_n = 1'b0;
    sig_a = '0; clr_a = '0; mode_a = '0;
    sig_b = '0; clr_b = '0; mode_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_a", 16'({pulse_a, level_a, event_a}), 16'h0);
    check("reset_b", 16'({pulse_b, level_b, event_b}), 16'h0);

    mode_a = 8'h0D;
    for (int i = 0; i < 27; i++) begin
      sig_a = tbl[i].sig;
      clr_a = tbl[i].clr;
      step();
      check($sformatf("vec%0d", i), 16'({pulse_a, level_a, event_a}),
            16'({tbl[i].pul, tbl[i].lvl, tbl[i].evt}));
    end
    clr_a = '0;

    // ch2 square wave, period 20, across modes 01/10/11/00
    mds = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp_cnt = '{1, 1, 2, 0};
    k = 0;
    for (int m = 0; m < 4; m++) begin
      mode_a = 8'(mds[m]) << 4;
      cnt = 0;
      for (int t = 0; t < 40; t++) begin
        wv[k] = ((k / 10) % 2) == 0;
        sig_a[2] = wv[k];
        step();
        check("wave_level", 16'(level_a[2]), 16'((k >= 5) ? wv[k-5] : 1'b0));
        if (t >= 20 && pulse_a[2]) cnt++;
        k++;
      end
      check($sformatf("wave_pulses_m%0d", m), 16'(cnt), 16'(exp_cnt[m]));
    end

    // ch3 clear held during the firing cycle keeps the event, next cycle clears it
    mode_a = 8'h40;
    sig_a[3] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      step();
      check("clr_prefire", 16'(pulse_a[3]), 16'h0);
    end
    clr_a[3] = 1'b1;
    step();
    check("clr_fire", 16'({pulse_a[3], event_a[3]}), 16'h3);
    step();
    check("clr_after", 16'({pulse_a[3], event_a[3]}), 16'h0);
    clr_a = '0;

    // async reset with ch0 mid-debounce, release with input high
    sig_a = '0;
    mode_a = 8'hFF;
    repeat (12) step();
    check("pre_rst_evt", 16'(event_a[3]), 16'h1);
    sig_a[0] = 1'b1;
    repeat (4) step();
    async_reset();
    for (int t = 1; t <= 5; t++) begin
      step();
      check("rst_rel_wait", 16'({pulse_a[0], level_a[0]}), 16'h0);
    end
    step();
    check("rst_rel_fire", 16'({pulse_a[0], level_a[0]}), 16'h3);

    // SYNC_STAGES=3, FILTER_CYCLES=1: all channels fire together 3 edges after capture
    mode_b = 8'hFF;
    sig_b = 4'hF;
    for (int t = 1; t <= 3; t++) begin
      step();
      check("b_wait", 16'(pulse_b), 16'h0);
    end
    step();
    check("b_fire", 16'({pulse_b, level_b}), 16'hFF);
    step();
    check("b_after", 16'(pulse_b), 16'h0);

    for (int n = 0; n < 2000; n++) begin
      if (n % 50 == 0) begin
        mode_a = 8'($urandom);
        mode_b = 8'($urandom);
      end
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) sig_a[c] = ~sig_a[c];
      sig_b = 4'($urandom);
      clr_a = 4'($urandom) & 4'($urandom) & 4'($urandom);
      clr_b = 4'($urandom) & 4'($urandom);
      step();
      if (n == 1000) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
